// File: rtl/mdu_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
// The core decoder imports mdu_op_t to map funct codes onto unit operations.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FIX
  } mdu_state_t;

  localparam logic [MDU_WIDTH-1:0] MDU_DIV0_QUOT = '1;

  // Even encodings (MULT, DIV) are the signed flavours.
  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic is_neg(input logic [MDU_WIDTH-1:0] v, input logic sgn);
    return sgn & v[MDU_WIDTH-1];
  endfunction

  function automatic logic [MDU_WIDTH-1:0] magnitude(input logic [MDU_WIDTH-1:0] v,
                                                     input logic sgn);
    return is_neg(v, sgn) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage (master) and the mult/div unit (slave).
interface mult_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fixup applied in a final cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mdu_state_t         state_q;
  mdu_op_t            op_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               div0_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               sgn;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  // prod_q low half holds the multiplier (multiply) or dividend/quotient (divide).
  // Because the partial remainder stays below the divisor, bit WIDTH of the
  // difference is set exactly when the trial subtraction would go negative.
  always_comb begin
    sgn        = op_is_signed(bus.op);
    mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift  = {rem_q, prod_q[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opb_q};
    div_fits   = ~div_diff[WIDTH];
    prod_fixed = neg_q ? -prod_q : prod_q;
    quot_fixed = div0_q ? MDU_DIV0_QUOT
                        : (neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0]);
    rem_fixed  = rem_neg_q ? -rem_q : rem_q;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      op_q      <= MDU_MULT;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      opb_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            neg_q     <= is_neg(bus.rs, sgn) ^ is_neg(bus.rt, sgn);
            rem_neg_q <= is_neg(bus.rs, sgn);
            div0_q    <= op_is_div(bus.op) && (bus.rt == '0);
            if (op_is_div(bus.op)) begin
              opb_q  <= magnitude(bus.rt, sgn);
              prod_q <= {{WIDTH{1'b0}}, magnitude(bus.rs, sgn)};
            end else begin
              opb_q  <= magnitude(bus.rs, sgn);
              prod_q <= {{WIDTH{1'b0}}, magnitude(bus.rt, sgn)};
            end
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MDU_CALC;
          end else begin
            if (bus.mthi) hi_q <= bus.rs;
            if (bus.mtlo) lo_q <= bus.rs;
          end
        end

        MDU_CALC: begin
          if (op_is_div(op_q)) begin
            rem_q              <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            prod_q[WIDTH-1:0]  <= {prod_q[WIDTH-2:0], div_fits};
          end else begin
            prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST) state_q <= MDU_FIX;
          else               cnt_q   <= cnt_q + 1'b1;
        end

        MDU_FIX: begin
          // A zero divisor leaves the dividend magnitude as remainder, so hi = rs.
          if (op_is_div(op_q)) begin
            hi_q <= rem_fixed;
            lo_q <= quot_fixed;
          end else begin
            {hi_q, lo_q} <= prod_fixed;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= MDU_IDLE;
        end

        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
